tetris_vga_render: RTL and testbench

TETRIS_VGA_RENDER -- requirements
Module: tetris_vga_render

---
 rtl/tetris_vga_render.sv | 162 ++++++++++++++++
 tb/tb_tetris_vga_render.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tetris_vga_render.sv
// 640x480@60 VGA renderer for a 12x20 Tetris playfield snapshot (20x20 px cells, white border).
// Define TETRIS_GRID_EN to draw dim grid lines through clear cells.
module tetris_vga_render (
    input  logic         clk,
    input  logic         rst,
    input  logic [239:0] data,
    output logic [3:0]   red,
    output logic [3:0]   green,
    output logic [3:0]   blue,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_tick
);

    logic         phase_r;
    logic         pix_en_s;
    logic [9:0]   hcnt_r;
    logic [9:0]   vcnt_r;
    logic [4:0]   hsub_r;
    logic [3:0]   hcell_r;
    logic [4:0]   vsub_r;
    logic [4:0]   vcell_r;
    logic [239:0] snap_r;
    logic         snap_now_s;
    logic         in_pf_s;
    logic         in_box_s;
    logic         visible_s;
    logic         hsync_s;
    logic         vsync_s;
    logic [7:0]   bit_idx_s;
    logic         cell_on_s;
    logic [11:0]  rgb_s;

    assign pix_en_s   = phase_r;
    assign snap_now_s = pix_en_s && (hcnt_r == 10'd0) && (vcnt_r == 10'd480);
    assign visible_s  = (hcnt_r < 10'd640) && (vcnt_r < 10'd480);
    assign in_pf_s    = (hcnt_r >= 10'd200) && (hcnt_r <= 10'd439) &&
                        (vcnt_r >= 10'd40)  && (vcnt_r <= 10'd439);
    assign in_box_s   = (hcnt_r >= 10'd196) && (hcnt_r <= 10'd443) &&
                        (vcnt_r >= 10'd36)  && (vcnt_r <= 10'd443);
    assign hsync_s    = !((hcnt_r >= 10'd656) && (hcnt_r <= 10'd751));
    assign vsync_s    = !((vcnt_r >= 10'd490) && (vcnt_r <= 10'd491));
    // row*12 + (11-col); leftmost screen column is the MSB of each row
    assign bit_idx_s  = {vcell_r, 3'b000} + {1'b0, vcell_r, 2'b00} + (8'd11 - {4'b0000, hcell_r});
    assign cell_on_s  = snap_r[bit_idx_s];

    // Pixel-enable phase: every other clk is a 25 MHz pixel slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= ~phase_r;
        end
    end

    // Horizontal/vertical raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_r <= 10'd0;
            vcnt_r <= 10'd0;
        end else if (pix_en_s) begin
            if (hcnt_r == 10'd799) begin
                hcnt_r <= 10'd0;
                if (vcnt_r == 10'd524) begin
                    vcnt_r <= 10'd0;
                end else begin
                    vcnt_r <= vcnt_r + 10'd1;
                end
            end else begin
                hcnt_r <= hcnt_r + 10'd1;
            end
        end
    end

    // Cell/sub-pixel counters re-aligned one step before the playfield edge; only meaningful inside it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsub_r  <= 5'd0;
            hcell_r <= 4'd0;
            vsub_r  <= 5'd0;
            vcell_r <= 5'd0;
        end else if (pix_en_s) begin
            if (hcnt_r == 10'd199) begin
                hsub_r  <= 5'd0;
                hcell_r <= 4'd0;
            end else if (hsub_r == 5'd19) begin
                hsub_r  <= 5'd0;
                hcell_r <= hcell_r + 4'd1;
            end else begin
                hsub_r  <= hsub_r + 5'd1;
            end
            if (hcnt_r == 10'd799) begin
                if (vcnt_r == 10'd39) begin
                    vsub_r  <= 5'd0;
                    vcell_r <= 5'd0;
                end else if (vsub_r == 5'd19) begin
                    vsub_r  <= 5'd0;
                    vcell_r <= vcell_r + 5'd1;
                end else begin
                    vsub_r  <= vsub_r + 5'd1;
                end
            end
        end
    end

    // Frame snapshot taken at the start of vertical blanking so the visible frame never tears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_r     <= 240'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= snap_now_s;
            if (snap_now_s) begin
                snap_r <= data;
            end
        end
    end

    // Colour selection for the current raster position
    always_comb begin
        rgb_s = 12'h000;
        if (!visible_s) begin
            rgb_s = 12'h000;
        end else if (in_pf_s) begin
            if (cell_on_s) begin
                rgb_s = 12'h0FF;
            end else begin
`ifdef TETRIS_GRID_EN
                if ((hsub_r == 5'd0) || (vsub_r == 5'd0)) begin
                    rgb_s = 12'h333;
                end else begin
                    rgb_s = 12'h000;
                end
`else
                rgb_s = 12'h000;
`endif
            end
        end else if (in_box_s) begin
            rgb_s = 12'hFFF;
        end else begin
            rgb_s = 12'h000;
        end
    end

    // Output stage: colour and sync registered together so they stay aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_en_s) begin
            red   <= rgb_s[11:8];
            green <= rgb_s[7:4];
            blue  <= rgb_s[3:0];
            hsync <= hsync_s;
            vsync <= vsync_s;
        end
    end

endmodule

// File: tb/tb_tetris_vga_render.sv
// Directed self-checking bench for tetris_vga_render: reset, sync timing, mapping, border, tearing.
module tb_tetris_vga_render;

    logic         clk;
    logic         rst;
    logic [239:0] data;
    logic [3:0]   red;
    logic [3:0]   green;
    logic [3:0]   blue;
    logic         hsync;
    logic         vsync;
    logic         frame_tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base   = 0;
    bit mon_on = 1'b0;
    int hs_low = 0;
    int vs_low = 0;
    int tick_n = 0;
    int tick_rel [2];

    localparam int FRAME_PIX = 420000;

    tetris_vga_render dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sync/tick statistics over the first two frames after the final reset release
    always @(negedge clk) begin
        if (mon_on && ((cyc - base) >= 2) && ((cyc - base) < 1680002)) begin
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (frame_tick && (tick_n < 2)) begin
                tick_rel[tick_n] = cyc - base;
                tick_n++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rel(input int r);
        while ((cyc - base) < r) @(negedge clk);
    endtask

    // Output for pixel n is held during clocks 2n+2 and 2n+3 after reset release
    task automatic at_pix(input int f, input int y, input int x);
        wait_rel(2 * (f * FRAME_PIX + y * 800 + x) + 2);
    endtask

    function automatic logic [31:0] rgb();
        return {20'd0, red, green, blue};
    endfunction

    initial begin
        rst  = 1'b0;
        data = '0;
        data[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rgb",   rgb(), 32'h000);
        check("reset_hsync", {31'd0, hsync}, 32'd1);
        check("reset_vsync", {31'd0, vsync}, 32'd1);
        check("reset_tick",  {31'd0, frame_tick}, 32'd0);

        rst  = 1'b1;
        base = cyc;
        at_pix(0, 300, 198);
        check("pre_reset_border", rgb(), 32'hFFF);
        #3 rst = 1'b0;
        #1;
        check("async_rst_rgb",   rgb(), 32'h000);
        check("async_rst_hsync", {31'd0, hsync}, 32'd1);
        check("async_rst_vsync", {31'd0, vsync}, 32'd1);
        check("async_rst_tick",  {31'd0, frame_tick}, 32'd0);
        repeat (3) @(negedge clk);

        rst    = 1'b1;
        base   = cyc;
        mon_on = 1'b1;
        wait_rel(1313);
        check("hsync_before_656", {31'd0, hsync}, 32'd1);
        wait_rel(1314);
        check("hsync_at_656", {31'd0, hsync}, 32'd0);
        check("vsync_line0",  {31'd0, vsync}, 32'd1);

        at_pix(0, 36, 195);
        check("outside_border_195_36", rgb(), 32'h000);
        at_pix(0, 36, 196);
        check("border_196_36", rgb(), 32'hFFF);
        at_pix(0, 45, 425);
        check("frame0_empty_snapshot", rgb(), 32'h000);

        wait_rel(768001);
        check("tick_before", {31'd0, frame_tick}, 32'd0);
        wait_rel(768002);
        check("tick_pulse", {31'd0, frame_tick}, 32'd1);
        wait_rel(768003);
        check("tick_single", {31'd0, frame_tick}, 32'd0);

        at_pix(1, 40, 420);
        check("bit0_top_left_of_cell", rgb(), 32'h0FF);
        at_pix(1, 40, 440);
        check("border_right_440_40", rgb(), 32'hFFF);
        at_pix(1, 45, 419);
        check("bit1_cell_clear", rgb(), 32'h000);
        at_pix(1, 59, 439);
        check("bit0_bottom_right", rgb(), 32'h0FF);
        at_pix(1, 65, 425);
        check("row1_clear", rgb(), 32'h000);
        at_pix(1, 100, 650);
        check("hblank_650_100", rgb(), 32'h000);

        at_pix(1, 200, 0);
        data = '0;
        data[239] = 1'b1;
        at_pix(1, 425, 205);
        check("midframe_change_hidden", rgb(), 32'h000);
        at_pix(1, 485, 100);
        check("vblank_100_485", rgb(), 32'h000);

        wait_rel(1680003);
        check("hsync_low_clks_2frames", hs_low, 32'd201600);
        check("vsync_low_clks_2frames", vs_low, 32'd6400);
        check("tick_count_2frames", tick_n, 32'd2);
        check("first_tick_position", tick_rel[0], 32'd768002);
        check("frame_period_clks", tick_rel[1] - tick_rel[0], 32'd840000);

        at_pix(2, 45, 425);
        check("old_image_gone", rgb(), 32'h000);
        at_pix(2, 420, 199);
        check("border_left_199_420", rgb(), 32'hFFF);
        at_pix(2, 420, 200);
        check("bit239_top_left", rgb(), 32'h0FF);
        at_pix(2, 425, 225);
        check("bit238_clear", rgb(), 32'h000);
        at_pix(2, 439, 219);
        check("bit239_bottom_right", rgb(), 32'h0FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
